// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability-counter debounce FSM,
// and registered level / press-pulse / toggle-latch outputs.
//
// state   | meaning
// LOW     | stable released, counter idle at 0
// RISING  | synced input is 1, counting toward acceptance of a press
// HIGH    | stable pressed, counter idle at 0
// FALLING | synced input is 0, counting toward acceptance of a release
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_clr_toggle,
  output logic o_level,
  output logic o_press,
  output logic o_toggle
);

  localparam logic [CNT_W-1:0] LP_CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_toggle;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_level_nxt;
  logic             w_toggle_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_state  <= LOW;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_press  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_s1     <= i_raw;
      r_s2     <= r_s1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_press  <= w_press_nxt;
      r_toggle <= w_toggle_nxt;
    end
  end

  // Any bounce during a qualifying run drops straight back to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      LOW: begin
        if (r_s2) begin
          w_state_nxt = RISING;
          w_cnt_nxt   = LP_CNT_ONE;
        end
      end
      RISING: begin
        if (!r_s2) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_TC) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      HIGH: begin
        if (!r_s2) begin
          w_state_nxt = FALLING;
          w_cnt_nxt   = LP_CNT_ONE;
        end
      end
      FALLING: begin
        if (r_s2) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_TC) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Clear wins over a coincident press so the latch always ends at 0.
  always_comb begin
    w_level_nxt  = (w_state_nxt == HIGH) || (w_state_nxt == FALLING);
    w_toggle_nxt = i_clr_toggle ? 1'b0 : (r_toggle ^ w_press_nxt);
  end

  assign o_level  = r_level;
  assign o_press  = r_press;
  assign o_toggle = r_toggle;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw button pins into debounced level, press pulse and
// toggle latch; each channel is fully independent.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             clr_toggle,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_toggle
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_raw        (btn_raw[g]),
      .i_clr_toggle (clr_toggle),
      .o_level      (btn_level[g]),
      .o_press      (btn_press[g]),
      .o_toggle     (btn_toggle[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations plus
// randomized bouncing inputs checked every cycle against a history-based model.
module tb_btn_conditioner;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int MAXE = 16384;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr_toggle;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_toggle;

  int n_assert = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .clr_toggle (clr_toggle),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_toggle (btn_toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw samples per edge; the synchronised value seen at edge k is the raw
  // sample from edge k-2. The level flips once D consecutive synced samples, all
  // taken after the previous flip/reset, differ from it.
  logic [N-1:0] raw_hist [MAXE];
  int           e = -1;
  int           last_flip [N];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_toggle;
  logic         m_diff;
  int           press_seen [N];

  function automatic logic s2_at(input int k, input int ch);
    if (k < 2) return 1'b0;
    return raw_hist[k-2][ch];
  endfunction

  always @(posedge clk) begin
    e++;
    m_press = '0;
    if (rst) begin
      raw_hist[e] = '0;
      if (e > 0) raw_hist[e-1] = '0;
      m_level  = '0;
      m_toggle = '0;
      for (int c = 0; c < N; c++) last_flip[c] = e;
    end else begin
      raw_hist[e] = btn_raw;
      for (int c = 0; c < N; c++) begin
        if (e - last_flip[c] >= D) begin
          m_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (s2_at(e - j, c) == m_level[c]) m_diff = 1'b0;
          if (m_diff) begin
            m_level[c]   = ~m_level[c];
            m_press[c]   = m_level[c];
            last_flip[c] = e;
          end
        end
      end
      if (clr_toggle) m_toggle = '0;
      else            m_toggle = m_toggle ^ m_press;
    end
    #1;
    chk("model_level", btn_level, m_level);
    chk("model_press", btn_press, m_press);
    chk("model_toggle", btn_toggle, m_toggle);
    for (int c = 0; c < N; c++) press_seen[c] += int'(btn_press[c]);
  end

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    btn_raw    = '0;
    clr_toggle = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < N; c++) press_seen[c] = 0;
  endtask

  int hold [N];

  initial begin
    rst        = 1'b1;
    btn_raw    = '1;
    clr_toggle = 1'b0;
    for (int c = 0; c < N; c++) press_seen[c] = 0;

    // Reset held with all buttons down, then release.
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_hold_level", btn_level, '0);
      chk("rst_hold_press", btn_press, '0);
      chk("rst_hold_toggle", btn_toggle, '0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("rst_rel_e4_level", btn_level, 4'h0);
    @(posedge clk); #2;
    chk("rst_rel_e5_level", btn_level, 4'hF);
    chk("rst_rel_e5_press", btn_press, 4'hF);

    // Clean press on channel 0.
    do_reset();
    btn_raw[0] = 1'b1;
    repeat (5) @(posedge clk); #2;
    chk("clean_e4_level", btn_level, 4'h0);
    @(posedge clk); #2;
    chk("clean_e5_level", btn_level, 4'h1);
    chk("clean_e5_press", btn_press, 4'h1);
    chk("clean_e5_toggle", btn_toggle, 4'h1);
    @(posedge clk); #2;
    chk("clean_e6_press", btn_press, 4'h0);
    chk("clean_e6_level", btn_level, 4'h1);
    repeat (5) @(posedge clk); #2;
    chk("clean_toggle_hold", btn_toggle, 4'h1);
    chk_int("clean_press_count", press_seen[0], 1);

    // Bounce rejection on channel 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      btn_raw[1] = ((i % 4) < 2);
      @(negedge clk);
    end
    btn_raw[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_level", btn_level, 4'h0);
    chk("bounce_toggle", btn_toggle, 4'h0);
    chk_int("bounce_press_count", press_seen[1], 0);

    // Bounce then settle on channel 2.
    do_reset();
    btn_raw[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn_raw[2] = 1'b0;
    @(negedge clk);
    btn_raw[2] = 1'b1;
    repeat (5) @(posedge clk); #2;
    chk("settle_f4_press", btn_press, 4'h0);
    @(posedge clk); #2;
    chk("settle_f5_press", btn_press, 4'h4);
    repeat (6) @(posedge clk); #2;
    chk_int("settle_press_count", press_seen[2], 1);

    // Two press/release cycles on channel 3.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      btn_raw[3] = 1'b1;
      repeat (8) @(negedge clk);
      chk_int("toggle_after_press", int'(btn_toggle[3]), (p == 0) ? 1 : 0);
      btn_raw[3] = 1'b0;
      repeat (8) @(negedge clk);
      chk_int("toggle_after_release", int'(btn_toggle[3]), (p == 0) ? 1 : 0);
      chk_int("level_after_release", int'(btn_level[3]), 0);
    end
    chk_int("toggle_press_count", press_seen[3], 2);

    // Clear coincident with a press on channel 0 whose toggle is already 1.
    do_reset();
    btn_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("prio_toggle_before", btn_toggle, 4'h1);
    btn_raw[0] = 1'b1;
    repeat (5) @(negedge clk);
    clr_toggle = 1'b1;
    @(posedge clk); #2;
    chk("prio_press", btn_press, 4'h1);
    chk("prio_toggle", btn_toggle, 4'h0);
    chk("prio_level", btn_level, 4'h1);
    @(negedge clk);
    clr_toggle = 1'b0;

    // Reset while channel 0 is mid-qualification, button held throughout.
    do_reset();
    btn_raw[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_level", btn_level, 4'h0);
    chk("midrst_toggle", btn_toggle, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("midrst_e4_level", btn_level, 4'h0);
    @(posedge clk); #2;
    chk("midrst_e5_level", btn_level, 4'h1);
    chk("midrst_e5_press", btn_press, 4'h1);

    // Randomized bouncing on all channels with occasional clear and reset.
    do_reset();
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          hold[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 12);
        end else begin
          hold[c]--;
        end
      end
      clr_toggle = ($urandom_range(0, 29) == 0);
      if (rst) rst = 1'b0;
      else     rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst        = 1'b0;
    clr_toggle = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
